rename_stage: RTL and testbench
===============================

// Module: rename_stage
// PURPOSE
//  2-wide register-rename stage between decode and dispatch. Maps rs1/rs2/rd to physical
//  registers through a speculative RAT and allocates new destinations from a free list.
//  Registers the renamed pair into an output pipeline register that feeds the dispatch
//  stage. Commit frees old mappings; flush restores speculative state from committed state.
// PARAMETERS
//  PHY_REGS   64  physical registers (power of two, > 32)
//  PHY_WIDTH  6   log2(PHY_REGS)
//  ARCH_REGS  32  architectural registers (fixed; from typedef_pkg)
// PORTS
//  clk                   in   1          clock
//  rst                   in   1          async reset, active-low (0 = reset)
//  flush                 in   1          mispredict/exception flush
//  stall_dispatch        in   1          downstream backpressure; hold output register
//  decode_instruction_0  in   instr_t    older decoded instr (valid, opcode, rd, rs1, rs2, pc, ...)
//  decode_instruction_1  in   instr_t    younger decoded instr
//  rename_ready          out  1          pair accepted this cycle when valid
//  rename_instruction_0  out  instr_t    registered; prd/prs1/prs2/old_prd filled
//  rename_instruction_1  out  instr_t    registered
//  alloc_valid_0/1       out  1          prd allocated this cycle (PRF busy-bit clear)
//  alloc_prd_0/1         out  PHY_WIDTH  allocated physical reg
//  commit_valid_0/1      in   1          retiring instr that allocated a prd (older = _0)
//  commit_rd_0/1         in   5          its arch rd
//  commit_prd_0/1        in   PHY_WIDTH  its prd
//  commit_old_prd_0/1    in   PHY_WIDTH  prd to free
// BEHAVIOUR
//  Reset: spec RAT[i] = commit RAT[i] = i. Free list holds 32..PHY_REGS-1 in order;
//   spec_head = commit_head = 0, tail = PHY_REGS-32, count = PHY_REGS-32.
//   rename_instruction_*.valid = 0, alloc_valid_* = 0.
//  writes_rd(x) = x.valid && x.rd != 0 && opcode not in {STORE, BRANCH}.
//   need = writes_rd(0) + writes_rd(1).
//  Readiness and alloc:
//   rename_ready = !flush && !stall_dispatch && (spec free count >= need).
//   accept = rename_ready && (valid_0 || valid_1); all-or-nothing per pair.
//   On accept: instr0 gets free[spec_head] if writes_rd(0); instr1 gets the next entry.
//   spec_head advances by need. alloc_* are combinational, asserted only on accept.
//  Mapping:
//   prs1/prs2 = spec RAT; arch reg 0 always maps to phys 0.
//   instr1 bypass: rs == instr0.rd with writes_rd(0) -> instr0.prd.
//   old_prd = RAT[rd] before this pair. If both write the same rd, instr1.old_prd = instr0.prd
//    and the RAT ends holding instr1.prd.
//   Latency 1: renamed pair visible on rename_instruction_* the cycle after accept.
//  Output register:
//   stall_dispatch && !flush -> hold contents.
//   !accept && !stall -> valid bits cleared.
//   flush -> valid bits cleared next cycle (highest priority).
//  Commit (in order, _0 before _1):
//   Each commit_valid writes commit RAT[rd] = prd, pushes old_prd at tail, tail++.
//   commit_head advances by the number of commits.
//   Free count = tail - spec_head (PHY_WIDTH+1 bits, never above PHY_REGS-32).
//  Flush: spec RAT := commit RAT and spec_head := commit_head, both including same-cycle
//   commit updates. Same-cycle commit frees are kept. No allocation in a flush cycle.
//  Reset mid-operation: all state returns immediately to reset values (async).
//  Assertions: free count never underflows; commit_head never passes spec_head.
// STRUCTURE
//  typedef_pkg: instr_t fields (prd, prs1, prs2, old_prd), ARCH_REGS, function writes_rd().
//  Sub-module rename_free_list: circular FIFO, depth PHY_REGS, 2-pop/2-push, holds
//   spec_head/commit_head/tail and restores on flush. RATs stay in rename_stage.
// TESTING
//  1 Reset, then decode 0 = ADDI x1,x0 and 1 = invalid -> ready=1, alloc_prd_0=32, next cycle
//    out0.prd=32, old_prd=1, prs1=0; free count = 31.
//  2 Pair ADD x5,x1,x2 / ADD x6,x5,x5 -> instr1 prs1=prs2=instr0.prd; RAT[6] updated.
//  3 Pair both writing x7 -> instr1.old_prd = instr0.prd; a later read of x7 gets instr1.prd.
//  4 Exhaust the free list (32 allocations) -> ready=0 and no alloc.
//    One commit frees 1 -> single-writer accepted; a pair needing 2 still stalls.
//  5 Allocate 4, commit 2, then flush -> RAT equals commit RAT, free count = 32 - 2 + 2 = 32,
//    outputs invalid next cycle.
//  6 stall_dispatch held 3 cycles with a valid pair present -> outputs stable, spec_head
//    unchanged, ready=0.

Source files
------------

// File: rtl/rename_stage_pkg.sv
// Shared types for the rename stage: decoded/renamed instruction record, sizes, and
// the predicate deciding whether an instruction needs a new destination register.
package rename_stage_pkg;

   localparam int ARCH_REGS = 32;
   localparam int PHY_REGS  = 64;
   localparam int PHY_WIDTH = 6;

   typedef enum logic [2:0] {
      OP_ALU, OP_ALUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL
   } opcode_t;

   typedef struct packed {
      logic                 valid;
      opcode_t              opcode;
      logic [4:0]           rd;
      logic [4:0]           rs1;
      logic [4:0]           rs2;
      logic [31:0]          pc;
      logic [PHY_WIDTH-1:0] prd;
      logic [PHY_WIDTH-1:0] prs1;
      logic [PHY_WIDTH-1:0] prs2;
      logic [PHY_WIDTH-1:0] old_prd;
   } instr_t;

   function automatic logic writes_rd(input instr_t x);
      return x.valid && (x.rd != 5'd0) && (x.opcode != OP_STORE) && (x.opcode != OP_BRANCH);
   endfunction

endpackage

// File: rtl/rename_stage_free_list.sv
// Circular free list, 2-pop (speculative head) / 2-push (commit tail); head data is combinational,
// pointer updates take effect next cycle; flush rewinds the speculative head to the committed head.
module rename_free_list
   import rename_stage_pkg::*;
#(
   parameter int DEPTH = PHY_REGS,
   parameter int AW    = PHY_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [1:0]    pop_cnt,
   input  logic          push_0,
   input  logic          push_1,
   input  logic [AW-1:0] push_dat_0,
   input  logic [AW-1:0] push_dat_1,
   output logic [AW-1:0] head_dat_0,
   output logic [AW-1:0] head_dat_1,
   output logic [AW:0]   free_cnt
);

   localparam logic [AW:0] FREE_MAX = (AW+1)'(DEPTH - ARCH_REGS);

   logic [AW-1:0] mem [DEPTH];
   logic [AW:0]   spec_head;
   logic [AW:0]   commit_head;
   logic [AW:0]   tail;
   logic [AW:0]   tail_1;
   logic [AW:0]   commit_head_nxt;
   logic [AW-1:0] head_idx_1;
   logic [1:0]    push_cnt;

   assign push_cnt        = {1'b0, push_0} + {1'b0, push_1};
   // Every commit consumes one entry that was allocated at the committed head.
   assign commit_head_nxt = commit_head + (AW+1)'(push_cnt);
   assign tail_1          = push_0 ? tail + (AW+1)'(1) : tail;
   assign head_idx_1      = spec_head[AW-1:0] + AW'(1);
   assign head_dat_0      = mem[spec_head[AW-1:0]];
   assign head_dat_1      = mem[head_idx_1];
   assign free_cnt        = tail - spec_head;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= AW'(ARCH_REGS + i);
         end
         spec_head   <= '0;
         commit_head <= '0;
         tail        <= FREE_MAX;
      end else begin
         if (push_0) mem[tail[AW-1:0]]   <= push_dat_0;
         if (push_1) mem[tail_1[AW-1:0]] <= push_dat_1;
         tail        <= tail + (AW+1)'(push_cnt);
         commit_head <= commit_head_nxt;
         spec_head   <= flush ? commit_head_nxt : spec_head + (AW+1)'(pop_cnt);
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         assert (free_cnt <= FREE_MAX);
         assert ((spec_head - commit_head) <= FREE_MAX);
      end
   end

endmodule

// File: rtl/rename_stage.sv
// 2-wide rename: speculative/committed RATs plus free list; renamed pair registered (latency 1).
// Pair is accepted all-or-nothing; stall_dispatch holds the output register and blocks acceptance.
module rename_stage
   import rename_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 stall_dispatch,
   input  instr_t               decode_instruction_0,
   input  instr_t               decode_instruction_1,
   output logic                 rename_ready,
   output instr_t               rename_instruction_0,
   output instr_t               rename_instruction_1,
   output logic                 alloc_valid_0,
   output logic                 alloc_valid_1,
   output logic [PHY_WIDTH-1:0] alloc_prd_0,
   output logic [PHY_WIDTH-1:0] alloc_prd_1,
   input  logic                 commit_valid_0,
   input  logic                 commit_valid_1,
   input  logic [4:0]           commit_rd_0,
   input  logic [4:0]           commit_rd_1,
   input  logic [PHY_WIDTH-1:0] commit_prd_0,
   input  logic [PHY_WIDTH-1:0] commit_prd_1,
   input  logic [PHY_WIDTH-1:0] commit_old_prd_0,
   input  logic [PHY_WIDTH-1:0] commit_old_prd_1
);

   typedef logic [PHY_WIDTH-1:0] preg_t;

   preg_t            spec_rat       [ARCH_REGS];
   preg_t            commit_rat     [ARCH_REGS];
   preg_t            commit_rat_nxt [ARCH_REGS];
   logic             wr_0, wr_1, accept;
   logic [1:0]       need;
   logic [PHY_WIDTH:0] free_cnt;
   preg_t            free_0, free_1, prd_0, prd_1;
   instr_t           ren_0, ren_1;

   assign wr_0         = writes_rd(decode_instruction_0);
   assign wr_1         = writes_rd(decode_instruction_1);
   assign need         = {1'b0, wr_0} + {1'b0, wr_1};
   assign rename_ready = !flush && !stall_dispatch && (free_cnt >= (PHY_WIDTH+1)'(need));
   assign accept       = rename_ready && (decode_instruction_0.valid || decode_instruction_1.valid);
   assign prd_0        = free_0;
   assign prd_1        = wr_0 ? free_1 : free_0;

   assign alloc_valid_0 = accept && wr_0;
   assign alloc_valid_1 = accept && wr_1;
   assign alloc_prd_0   = prd_0;
   assign alloc_prd_1   = prd_1;

   rename_free_list u_free_list (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .pop_cnt    (accept ? need : 2'd0),
      .push_0     (commit_valid_0),
      .push_1     (commit_valid_1),
      .push_dat_0 (commit_old_prd_0),
      .push_dat_1 (commit_old_prd_1),
      .head_dat_0 (free_0),
      .head_dat_1 (free_1),
      .free_cnt   (free_cnt)
   );

   // Younger instruction sees the older one's new destination, not the stale RAT entry.
   always_comb begin
      ren_0         = decode_instruction_0;
      ren_0.prs1    = spec_rat[decode_instruction_0.rs1];
      ren_0.prs2    = spec_rat[decode_instruction_0.rs2];
      ren_0.old_prd = spec_rat[decode_instruction_0.rd];
      ren_0.prd     = wr_0 ? prd_0 : '0;
      ren_1         = decode_instruction_1;
      ren_1.prs1    = (wr_0 && decode_instruction_1.rs1 == decode_instruction_0.rd)
                      ? prd_0 : spec_rat[decode_instruction_1.rs1];
      ren_1.prs2    = (wr_0 && decode_instruction_1.rs2 == decode_instruction_0.rd)
                      ? prd_0 : spec_rat[decode_instruction_1.rs2];
      ren_1.old_prd = (wr_0 && decode_instruction_1.rd == decode_instruction_0.rd)
                      ? prd_0 : spec_rat[decode_instruction_1.rd];
      ren_1.prd     = wr_1 ? prd_1 : '0;
   end

   always_comb begin
      commit_rat_nxt = commit_rat;
      if (commit_valid_0 && commit_rd_0 != 5'd0) commit_rat_nxt[commit_rd_0] = commit_prd_0;
      if (commit_valid_1 && commit_rd_1 != 5'd0) commit_rat_nxt[commit_rd_1] = commit_prd_1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ARCH_REGS; i++) begin
            spec_rat[i]   <= preg_t'(i);
            commit_rat[i] <= preg_t'(i);
         end
      end else begin
         commit_rat <= commit_rat_nxt;
         if (flush) begin
            spec_rat <= commit_rat_nxt;
         end else if (accept) begin
            if (wr_0) spec_rat[decode_instruction_0.rd] <= prd_0;
            if (wr_1) spec_rat[decode_instruction_1.rd] <= prd_1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rename_instruction_0 <= '0;
         rename_instruction_1 <= '0;
      end else if (flush) begin
         rename_instruction_0.valid <= 1'b0;
         rename_instruction_1.valid <= 1'b0;
      end else if (!stall_dispatch) begin
         if (accept) begin
            rename_instruction_0 <= ren_0;
            rename_instruction_1 <= ren_1;
         end else begin
            rename_instruction_0.valid <= 1'b0;
            rename_instruction_1.valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: hand-computed physical register numbers per step.
module tb_rename_stage;
   import rename_stage_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst, flush, stall_dispatch;
   instr_t               d0, d1, r0, r1;
   logic                 rename_ready, av0, av1;
   logic [PHY_WIDTH-1:0] ap0, ap1;
   logic                 cv0, cv1;
   logic [4:0]           crd0, crd1;
   logic [PHY_WIDTH-1:0] cprd0, cprd1, cold0, cold1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rename_stage dut (
      .clk                  (clk),
      .rst                  (rst),
      .flush                (flush),
      .stall_dispatch       (stall_dispatch),
      .decode_instruction_0 (d0),
      .decode_instruction_1 (d1),
      .rename_ready         (rename_ready),
      .rename_instruction_0 (r0),
      .rename_instruction_1 (r1),
      .alloc_valid_0        (av0),
      .alloc_valid_1        (av1),
      .alloc_prd_0          (ap0),
      .alloc_prd_1          (ap1),
      .commit_valid_0       (cv0),
      .commit_valid_1       (cv1),
      .commit_rd_0          (crd0),
      .commit_rd_1          (crd1),
      .commit_prd_0         (cprd0),
      .commit_prd_1         (cprd1),
      .commit_old_prd_0     (cold0),
      .commit_old_prd_1     (cold1)
   );

   function automatic instr_t mk(input opcode_t op, input int rd, input int rs1, input int rs2);
      instr_t x;
      x        = '0;
      x.valid  = 1'b1;
      x.opcode = op;
      x.rd     = 5'(rd);
      x.rs1    = 5'(rs1);
      x.rs2    = 5'(rs2);
      x.pc     = 32'h0000_1000;
      return x;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; stall_dispatch = 1'b0;
      d0 = '0; d1 = '0;
      cv0 = 1'b0; cv1 = 1'b0; crd0 = '0; crd1 = '0;
      cprd0 = '0; cprd1 = '0; cold0 = '0; cold1 = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out0_valid", r0.valid, 0);
      chk("rst_out1_valid", r1.valid, 0);
      chk("rst_alloc_valid_0", av0, 0);
      chk("rst_free_cnt", dut.u_free_list.free_cnt, 32);
      rst = 1'b1;
      tick();

      // 1: single writer ADDI x1,x0
      d0 = mk(OP_ALUI, 1, 0, 0); d1 = '0;
      #1;
      chk("t1_ready", rename_ready, 1);
      chk("t1_alloc_valid_0", av0, 1);
      chk("t1_alloc_prd_0", ap0, 32);
      chk("t1_alloc_valid_1", av1, 0);
      tick();
      chk("t1_out0_valid", r0.valid, 1);
      chk("t1_out0_prd", r0.prd, 32);
      chk("t1_out0_old_prd", r0.old_prd, 1);
      chk("t1_out0_prs1", r0.prs1, 0);
      chk("t1_out1_valid", r1.valid, 0);
      chk("t1_free_cnt", dut.u_free_list.free_cnt, 31);
      d0 = '0;
      tick();
      chk("idle_out0_valid", r0.valid, 0);

      // 2: intra-pair bypass
      d0 = mk(OP_ALU, 5, 1, 2); d1 = mk(OP_ALU, 6, 5, 5);
      #1;
      chk("t2_alloc_prd_0", ap0, 33);
      chk("t2_alloc_valid_1", av1, 1);
      chk("t2_alloc_prd_1", ap1, 34);
      tick();
      chk("t2_out0_prs1", r0.prs1, 32);
      chk("t2_out0_prs2", r0.prs2, 2);
      chk("t2_out0_old_prd", r0.old_prd, 5);
      chk("t2_out1_prs1", r1.prs1, 33);
      chk("t2_out1_prs2", r1.prs2, 33);
      chk("t2_out1_prd", r1.prd, 34);
      chk("t2_out1_old_prd", r1.old_prd, 6);
      chk("t2_rat6", dut.spec_rat[6], 34);
      chk("t2_free_cnt", dut.u_free_list.free_cnt, 29);

      // 3: both write x7
      d0 = mk(OP_ALU, 7, 5, 6); d1 = mk(OP_ALU, 7, 7, 1);
      tick();
      chk("t3_out0_prd", r0.prd, 35);
      chk("t3_out0_old_prd", r0.old_prd, 7);
      chk("t3_out1_prd", r1.prd, 36);
      chk("t3_out1_old_prd", r1.old_prd, 35);
      chk("t3_out1_prs1", r1.prs1, 35);
      chk("t3_out1_prs2", r1.prs2, 32);
      chk("t3_rat7", dut.spec_rat[7], 36);
      d0 = mk(OP_STORE, 9, 7, 1); d1 = mk(OP_BRANCH, 3, 7, 7);
      #1;
      chk("t3_st_br_ready", rename_ready, 1);
      chk("t3_st_alloc_valid_0", av0, 0);
      chk("t3_br_alloc_valid_1", av1, 0);
      tick();
      chk("t3_st_out0_valid", r0.valid, 1);
      chk("t3_st_out0_prs1", r0.prs1, 36);
      chk("t3_st_free_cnt", dut.u_free_list.free_cnt, 27);
      d0 = mk(OP_ALU, 8, 7, 0); d1 = '0;
      tick();
      chk("t3_x8_prs1", r0.prs1, 36);
      chk("t3_x8_prd", r0.prd, 37);

      // 4: exhaust the free list
      for (int i = 0; i < 13; i++) begin
         d0 = mk(OP_ALUI, 10, 0, 0); d1 = mk(OP_ALUI, 11, 0, 0);
         tick();
      end
      chk("t4_last_out0_prd", r0.prd, 62);
      chk("t4_last_out1_prd", r1.prd, 63);
      chk("t4_free_cnt_empty", dut.u_free_list.free_cnt, 0);
      d0 = mk(OP_ALUI, 12, 0, 0); d1 = '0;
      #1;
      chk("t4_empty_ready", rename_ready, 0);
      chk("t4_empty_alloc_valid_0", av0, 0);
      tick();
      chk("t4_empty_out0_valid", r0.valid, 0);
      d0 = '0;
      cv0 = 1'b1; crd0 = 5'd1; cprd0 = 6'd32; cold0 = 6'd1;
      tick();
      cv0 = 1'b0;
      chk("t4_commit_free_cnt", dut.u_free_list.free_cnt, 1);
      d0 = mk(OP_ALUI, 12, 0, 0); d1 = mk(OP_ALUI, 13, 0, 0);
      #1;
      chk("t4_pair_ready", rename_ready, 0);
      tick();
      d1 = '0;
      #1;
      chk("t4_single_ready", rename_ready, 1);
      chk("t4_single_alloc_prd_0", ap0, 1);
      tick();
      chk("t4_single_out0_prd", r0.prd, 1);
      chk("t4_single_free_cnt", dut.u_free_list.free_cnt, 0);
      d0 = '0;

      // 5: async reset, allocate 4, commit 2 with flush
      rst = 1'b0;
      #1;
      chk("t5_async_rst_out0_valid", r0.valid, 0);
      chk("t5_async_rst_free_cnt", dut.u_free_list.free_cnt, 32);
      rst = 1'b1;
      tick();
      d0 = mk(OP_ALUI, 1, 0, 0); d1 = mk(OP_ALUI, 2, 0, 0);
      tick();
      d0 = mk(OP_ALUI, 3, 0, 0); d1 = mk(OP_ALUI, 4, 0, 0);
      tick();
      chk("t5_out0_prd", r0.prd, 34);
      chk("t5_free_cnt_pre", dut.u_free_list.free_cnt, 28);
      flush = 1'b1;
      cv0 = 1'b1; crd0 = 5'd1; cprd0 = 6'd32; cold0 = 6'd1;
      cv1 = 1'b1; crd1 = 5'd2; cprd1 = 6'd33; cold1 = 6'd2;
      d0 = mk(OP_ALUI, 5, 0, 0); d1 = '0;
      #1;
      chk("t5_flush_ready", rename_ready, 0);
      chk("t5_flush_alloc_valid_0", av0, 0);
      tick();
      flush = 1'b0; cv0 = 1'b0; cv1 = 1'b0;
      chk("t5_out0_valid", r0.valid, 0);
      chk("t5_out1_valid", r1.valid, 0);
      chk("t5_free_cnt", dut.u_free_list.free_cnt, 32);
      chk("t5_rat1", dut.spec_rat[1], 32);
      chk("t5_rat2", dut.spec_rat[2], 33);
      chk("t5_rat3", dut.spec_rat[3], 3);
      chk("t5_rat4", dut.spec_rat[4], 4);
      #1;
      chk("t5_post_alloc_prd_0", ap0, 34);
      tick();
      d0 = '0;

      // 6: stall holds the output register
      d0 = mk(OP_ALU, 9, 5, 0); d1 = mk(OP_ALU, 10, 9, 9);
      tick();
      chk("t6_out0_prd", r0.prd, 35);
      chk("t6_out0_prs1", r0.prs1, 34);
      chk("t6_out1_prs1", r1.prs1, 35);
      chk("t6_out1_prd", r1.prd, 36);
      stall_dispatch = 1'b1;
      d0 = mk(OP_ALUI, 11, 0, 0); d1 = mk(OP_ALUI, 12, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t6_stall_ready", rename_ready, 0);
         chk("t6_stall_alloc_valid_0", av0, 0);
         tick();
         chk("t6_stall_out0_valid", r0.valid, 1);
         chk("t6_stall_out0_prd", r0.prd, 35);
         chk("t6_stall_out1_prd", r1.prd, 36);
         chk("t6_stall_free_cnt", dut.u_free_list.free_cnt, 29);
      end
      stall_dispatch = 1'b0;
      #1;
      chk("t6_release_ready", rename_ready, 1);
      tick();
      chk("t6_release_out0_prd", r0.prd, 37);
      chk("t6_release_out1_prd", r1.prd, 38);
      d0 = '0; d1 = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
